// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop, LSB first.
// Operands load in parallel on start; the result is presented in parallel with a done pulse.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sr, b_sr, acc, acc_next;
    logic [CNT_W-1:0] cnt;
    logic             c, s, c_next, accept, last;

    assign s      = a_sr[0] ^ b_sr[0] ^ c;
    assign c_next = (a_sr[0] & b_sr[0]) | (a_sr[0] & c) | (b_sr[0] & c);
    assign accept = start && (state == IDLE || state == DONE);
    assign last   = (cnt == CNT_W'(WIDTH - 1));

    // A 1-bit accumulator has no upper bits to carry along.
    generate
        if (WIDTH == 1) begin : g_acc1
            assign acc_next = s;
        end else begin : g_accn
            assign acc_next = {s, acc[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last)  state_next = DONE;
            DONE:    state_next = start ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    // sum/cout only move on the final-bit edge so they hold through the next operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr <= '0;
            b_sr <= '0;
            acc  <= '0;
            c    <= 1'b0;
            cnt  <= '0;
            sum  <= '0;
            cout <= 1'b0;
        end else if (accept) begin
            a_sr <= a;
            b_sr <= b;
            c    <= cin;
            cnt  <= '0;
        end else if (state == SHIFT) begin
            acc  <= acc_next;
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            c    <= c_next;
            cnt  <= cnt + 1'b1;
            if (last) begin
                sum  <= acc_next;
                cout <= c_next;
            end
        end
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial N-bit adder: the addition counterpart of our full subtractor. It uses a single full-adder cell plus a carry flip-flop, one bit per clock, LSB first. Operands are loaded in parallel on a start pulse. The result is presented in parallel with a one-cycle done pulse. It serves as the area-minimal arithmetic unit in the sequential datapath labs and as the reference partner for the serial subtractor.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 1..32)
CNT_W, 6, bit-counter width; must satisfy 2**CNT_W > WIDTH

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled on rising clk; accepted only in IDLE or DONE
a  input  WIDTH  augend; captured on the accepting edge only
b  input  WIDTH  addend; captured on the accepting edge only
cin  input  1  carry-in; captured on the accepting edge only
busy  output  1  high while state is SHIFT
done  output  1  one-cycle pulse; sum/cout valid from this cycle onward
sum  output  WIDTH  registered result (a+b+cin) mod 2**WIDTH
cout  output  1  registered carry-out of the MSB

Behaviour:
- Clocking and reset: one clock domain; reset is asynchronous and active-low.
- Reset values: busy=0, done=0, sum=0, cout=0, state=IDLE, internal shift registers, carry and counter all 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: start=1 at a rising edge does the following:
  - load a_sr<=a, b_sr<=b, c<=cin, cnt<=0
  - go to SHIFT
  - start=0 keeps the block in IDLE.
- SHIFT: every edge does the following:
  - compute s = a_sr[0]^b_sr[0]^c and c_next = majority(a_sr[0],b_sr[0],c)
  - acc <= {s, acc[WIDTH-1:1]}, a_sr and b_sr shift right with 0 fill, c <= c_next, cnt <= cnt+1
  - on the edge where cnt==WIDTH-1 (the final bit): sum <= {s, acc[WIDTH-1:1]}, cout <= c_next, go to DONE.
- DONE: done=1 for exactly this cycle.
  - start=1: accepted exactly as in IDLE (back-to-back operation, no bubble); go to SHIFT.
  - otherwise: go to IDLE.
- Output decode: busy=1 iff state==SHIFT; done=1 iff state==DONE; both are decoded from state registers, not combinational from inputs.
- Latency: start accepted at edge E0. Bit i is processed at edge E(i+1). sum/cout update at edge E(WIDTH). done is high in the cycle between E(WIDTH) and E(WIDTH+1). Throughput is one result per WIDTH+1 cycles.
- sum/cout hold their last value through IDLE and through the next SHIFT phase. They change only on a final-bit edge or on reset.
- While in SHIFT: start is ignored, and changes on a, b, cin have no effect.
- WIDTH=1: the single SHIFT edge is also the final edge, so done follows start by 2 edges.
- Overflow: cout carries the (WIDTH+1)-th bit. No saturation and no signed overflow flag.
- Reset asserted mid-operation: all state clears immediately (no clock needed), the result in progress is discarded, and done does not pulse. After release the block sits in IDLE until a new start.

Test Plan:
- WIDTH=8, a=0x35, b=0x4A, cin=0, start for 1 cycle -> busy high 8 cycles; done pulses on cycle 9 after the start edge; sum=0x7F, cout=0.
- WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- WIDTH=1: sweep {a,b,cin} through all 8 combinations (toggling at /80,/40,/20 ns like the subtractor bench) -> {cout,sum} matches the full-adder truth table: 00,01,01,10,01,10,10,11.
- start held high and a, b changed during SHIFT (first op 0x10+0x20) -> result 0x30. Operation is not restarted. Because start is still high in the DONE cycle, a second operation begins immediately with the a, b present on that edge.
- Back-to-back: first op 0x01+0x02, start asserted exactly in the DONE cycle with 0x80+0x80 -> first done shows sum=0x03; second done 9 cycles later shows sum=0x00, cout=1.
- rst_n pulsed low at cycle 4 of SHIFT -> busy, done, sum, cout go to 0 asynchronously. No done pulse follows. A subsequent start of 0x12+0x34 yields sum=0x46.
